// File: rtl/fb_access_scheduler_if.sv
// rtl/fb_access_scheduler_if.sv - draw-write and framebuffer RAM bus bundle
// Purpose: groups the GPU write handshake and the single-port RAM bus.
//   wr_valid/wr_ready : draw write handshake, wr_x/wr_y/wr_rgb : write pixel
//   mem_addr/mem_we/mem_wdata : RAM command, mem_rdata : RAM read data (1-cycle latency)
// Modports: slave = scheduler side, master = requester/RAM side.
interface fb_access_scheduler_if #(
    parameter int ADDR_W = 19
);
    logic              wr_valid;
    logic              wr_ready;
    logic [9:0]        wr_x;
    logic [8:0]        wr_y;
    logic [23:0]       wr_rgb;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [23:0]       mem_wdata;
    logic [23:0]       mem_rdata;

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_access_scheduler.sv
// rtl/fb_access_scheduler.sv - framebuffer RAM arbiter between LCD scanout and draw writes
// Purpose: one memory op per cycle; scanout reads prefetch into a pixel FIFO,
//   draw writes take the remaining cycles. Optional macro FB_STARVE_GUARD_EN adds
//   a write-starvation counter that forces a write grant after STARVE_LIMIT waits.
// Ports: Dclk/reset (sync, active-high); frame_start (flush + restart fetch);
//   pix_pop/pix_rgb/pix_valid/underflow/fifo_level (scanout side);
//   bus (slave modport): draw write handshake and RAM bus.
module fb_access_scheduler #(
    parameter int          H_ACTIVE      = 800,
    parameter int          V_ACTIVE      = 480,
    parameter int          ADDR_W        = 19,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          LOW_WATER     = 4,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
`ifdef FB_STARVE_GUARD_EN
    ,
    parameter int          STARVE_LIMIT  = 64
`endif
) (
    input  logic                          Dclk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          pix_pop,
    output logic [23:0]                   pix_rgb,
    output logic                          pix_valid,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    fb_access_scheduler_if.slave          bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W:0]      DEPTH_C   = (LVL_W+1)'(FIFO_DEPTH);
    localparam logic [LVL_W:0]      LOW_C     = (LVL_W+1)'(LOW_WATER);
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0]   H_MUL     = ADDR_W'(H_ACTIVE);
    localparam logic [9:0]          H_LIM     = 10'(H_ACTIVE);
    localparam logic [8:0]          V_LIM     = 9'(V_ACTIVE);

    logic [23:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [23:0]       pix_rgb_q, pix_rgb_d;
    logic              underflow_q, underflow_d;

    logic [LVL_W:0]    occ;
    logic              fetch_ok, urgent, force_wr, do_read, do_write, in_range;
    logic              push, pop_ok, pop_hit;
    logic [ADDR_W-1:0] wr_addr, mem_addr_c;
    logic              mem_we_c, wr_ready_c;
    logic [23:0]       mem_wdata_c;

`ifdef FB_STARVE_GUARD_EN
    localparam int          SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_q, starve_d;

    // Forced grant still needs one buffered pixel so the LCD is not starved instead.
    assign force_wr = bus.wr_valid && (starve_q == STARVE_C) && (level_q != '0);

    always_comb begin
        starve_d = starve_q;
        if (!bus.wr_valid || wr_ready_c) begin
            starve_d = '0;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge Dclk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_wr = 1'b0;
`endif

    // Arbitration: scanout first when below low water or when nobody wants to write.
    always_comb begin
        occ      = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
        fetch_ok = (occ < DEPTH_C) && !frame_start;
        urgent   = occ < LOW_C;
        do_read  = !reset && fetch_ok && (urgent || !bus.wr_valid) && !force_wr;
        do_write = !reset && !do_read && bus.wr_valid;
        in_range = (bus.wr_x < H_LIM) && (bus.wr_y < V_LIM);
        wr_addr  = ADDR_W'(bus.wr_y) * H_MUL + ADDR_W'(bus.wr_x);

        wr_ready_c  = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        mem_addr_c  = mem_addr_q;
        if (reset) begin
            mem_addr_c = '0;
        end else if (do_read) begin
            mem_addr_c = fetch_addr_q;
        end else if (do_write) begin
            wr_ready_c = 1'b1;
            // Off-screen writes are acknowledged but never reach the RAM.
            if (in_range) begin
                mem_we_c    = 1'b1;
                mem_addr_c  = wr_addr;
                mem_wdata_c = bus.wr_rgb;
            end
        end
    end

    assign bus.wr_ready  = wr_ready_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    // FIFO / fetch state. frame_start both discards the word returning now and
    // suppresses the pop, so a new frame always starts from a clean FIFO.
    always_comb begin
        push    = inflight_q && !frame_start;
        pop_ok  = pix_pop && !frame_start;
        pop_hit = pop_ok && (level_q != '0);

        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_addr_d = fetch_addr_q;
        pix_rgb_d    = pix_rgb_q;
        underflow_d  = underflow_q;
        inflight_d   = do_read;
        mem_addr_d   = mem_addr_c;
        level_d      = level_q + LVL_W'(push) - LVL_W'(pop_hit);

        if (do_read) begin
            fetch_addr_d = (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_hit) begin
            pix_rgb_d = fifo_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end else if (pop_ok) begin
            pix_rgb_d   = UNDERFLOW_RGB;
            underflow_d = 1'b1;
        end
        if (frame_start) begin
            level_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fetch_addr_d = '0;
        end
    end

    always_ff @(posedge Dclk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            inflight_q   <= 1'b0;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            pix_rgb_q    <= '0;
            underflow_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            inflight_q   <= inflight_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            pix_rgb_q    <= pix_rgb_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge Dclk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign pix_rgb    = pix_rgb_q;
    assign pix_valid  = (level_q != '0);
    assign underflow  = underflow_q;
    assign fifo_level = level_q;
endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: LCD scanout (read) and the GPU draw engine (write).
- Scanout reads are prefetched into a small pixel FIFO so the LCD interface can pop one pixel per active Dclk with no stalls.
- Draw writes use a valid/ready handshake and get whatever memory cycles scanout does not need.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, framebuffer address width
FIFO_DEPTH, 16, scanout prefetch FIFO entries (power of 2)
LOW_WATER, 4, occupancy below which scanout reads have absolute priority
UNDERFLOW_RGB, 24'hFF00FF, pixel emitted when popping an empty FIFO
STARVE_LIMIT, 64, write-wait cycles before a forced write grant (optional feature only)

Ports:
Dclk  in  1  pixel/system clock, all logic on rising edge
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle pulse before the first active pixel of a frame
pix_pop  in  1  scanout consumes one pixel (asserted while x/y active)
pix_rgb  out  24  registered pixel {R,G,B} for the LCD
pix_valid  out  1  FIFO non-empty
underflow  out  1  sticky: a pop found the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO entries
wr_valid  in  1  draw write request
wr_ready  out  1  write accepted this cycle
wr_x  in  10  write pixel x
wr_y  in  9  write pixel y
wr_rgb  in  24  write pixel colour
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  24  RAM write data
mem_rdata  in  24  RAM read data, valid one cycle after a read issue

Behaviour:
- Reset: pix_rgb=0, pix_valid=0, underflow=0, fifo_level=0, wr_ready=0, mem_we=0, mem_addr=0, mem_wdata=0. The fetch address and in-flight flag are cleared. Reset mid-operation discards all FIFO and in-flight data.
- One memory operation per cycle. mem_* and wr_ready are combinational from the current-cycle arbitration decision.
- occ = fifo_level + inflight (0/1).
- fetch_ok = occ < FIFO_DEPTH and frame_start=0.
- urgent = occ < LOW_WATER.
- Decision, in priority order:
  - fetch_ok and (urgent or !wr_valid): issue read. mem_addr=fetch_addr, mem_we=0, inflight set for the next cycle.
  - else wr_valid: grant write. wr_ready=1; mem_addr=wr_y*H_ACTIVE+wr_x; mem_we=1; mem_wdata=wr_rgb.
  - else idle: mem_we=0, mem_addr holds last value.
- Out-of-range write (wr_x>=H_ACTIVE or wr_y>=V_ACTIVE): when granted, wr_ready=1 but mem_we=0. The write is dropped and the cycle is consumed.
- Read return: mem_rdata is pushed into the FIFO in the cycle after issue, unless a frame_start occurred in between.
- fetch_addr increments per issued read and wraps from H_ACTIVE*V_ACTIVE-1 to 0.
- Pop:
  - pix_pop with level>0: pix_rgb <= FIFO head; level decrements.
  - pix_pop with level=0: pix_rgb <= UNDERFLOW_RGB, underflow <= 1; level unchanged.
  - Push and pop in the same cycle: level unchanged.
  - The pushed word never bypasses to pix_rgb in the same cycle.
- underflow clears only on reset.
- frame_start:
  - Flushes the FIFO (level=0 next cycle) and sets fetch_addr=0.
  - Data returning from a read issued the cycle before is discarded.
  - A pix_pop in the same cycle is ignored: pix_rgb holds, no underflow.
  - No read is issued that cycle; a pending write may be granted.
- pix_valid = (fifo_level != 0), registered together with the level.

Optional Feature:
- Macro: FB_STARVE_GUARD_EN.
- When defined: a counter increments each cycle wr_valid=1 and wr_ready=0, and clears on grant or when wr_valid=0. When the counter reaches STARVE_LIMIT, the next cycle grants the write even if urgent, provided fifo_level>=1; the counter then clears.
- When undefined: no counter is built and arbitration is exactly as in Behaviour, so writes can starve indefinitely.

Test Plan:
- Reset, then frame_start, then no writes/pops: reads issued at addresses 0..15 on consecutive cycles → fifo_level=16 after 17 cycles, no further reads, pix_valid=1.
- FIFO full, wr_valid held high, single pix_pop bringing occ to 15: writes granted every cycle. Pops driving occ to 3 (<LOW_WATER=4): read granted, wr_ready=0 that cycle.
- Write wr_x=3, wr_y=2, wr_rgb=24'h123456 with FIFO full → mem_addr=1603, mem_we=1, mem_wdata=24'h123456, wr_ready=1.
- Write wr_x=800, wr_y=0 → wr_ready=1, mem_we=0, no RAM change.
- pix_pop with level 0 → pix_rgb=24'hFF00FF next cycle, underflow=1, held until reset.
- frame_start one cycle after a read issue at address 383999 → fifo_level=0, returned data dropped, next read at address 0. Separately, a continuous run crossing 383999 wraps to address 0.
